// File: rtl/dbnc_sched.sv
// rtl/dbnc_sched.sv - round-robin scheduler sharing one debounce timer among N buttons
// Serves one mismatching channel per timer period and commits it only if it persists.
module dbnc_sched #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    btn_i,
  input  logic            times_up_i,
  output logic            strt_o,
  output logic [N-1:0]    btn_db_o,
  output logic [N-1:0]    press_o,
  output logic [N-1:0]    release_o,
  output logic            busy_o,
  output logic [SELW-1:0] sel_o
);

  typedef enum logic [2:0] {IDLE, START, WAIT, SAMPLE, RECOVER} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sync1_q, bs_q, btn_db_q, press_q, release_q, mm;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, win_idx;
  logic [SELW:0]   probe;
  logic            win_found, strt_q, busy_q, chg;

  assign mm  = bs_q ^ btn_db_q;
  assign chg = bs_q[sel_q] != btn_db_q[sel_q];

  // Wrapped search starting at ptr; the extra probe bit keeps ptr+k from overflowing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int k = 0; k < N; k++) begin
      probe = {1'b0, ptr_q} + (SELW+1)'(k);
      if (probe >= (SELW+1)'(N)) probe = probe - (SELW+1)'(N);
      if (!win_found && mm[probe[SELW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = probe[SELW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        // A timer still showing expiry has not reloaded yet; starting it now would be lost.
        if (!times_up_i && win_found) begin
          sel_d   = win_idx;
          state_d = START;
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (times_up_i) state_d = SAMPLE;
      SAMPLE: begin
        ptr_d   = (sel_q == SELW'(N-1)) ? '0 : sel_q + 1'b1;
        state_d = RECOVER;
      end
      RECOVER: if (!times_up_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      bs_q      <= '0;
      btn_db_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      strt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      bs_q      <= sync1_q;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      strt_q    <= (state_d == START);
      busy_q    <= (state_d != IDLE);
      press_q   <= '0;
      release_q <= '0;
      if (state_q == SAMPLE && chg) begin
        btn_db_q[sel_q]  <= bs_q[sel_q];
        press_q[sel_q]   <= bs_q[sel_q];
        release_q[sel_q] <= ~bs_q[sel_q];
      end
    end
  end

  assign strt_o    = strt_q;
  assign btn_db_o  = btn_db_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign busy_o    = busy_q;
  assign sel_o     = sel_q;

endmodule

// File: doc/dbnc_sched.md
# dbnc_sched

Round-robin scheduler that shares one millisecond debounce timer among `N` pushbutton channels. It synchronizes the raw button inputs and finds a channel whose level differs from its debounced value. It then starts the shared timer for that channel, re-samples the channel when the timer reports expiry, and commits or rejects the change. The block sits between the board pushbuttons and the user logic, next to the shared debounce timer, which it drives through a `strt`/`times_up` handshake.

## Interface
- `N`, 4: number of button channels, 2..16. Values that are not a power of two are legal.
- `SELW`, `$clog2(N)`: width of the channel index. Derived; do not override.

- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn`, in, N: raw, asynchronous pushbutton levels.
- `times_up`, in, 1: from the shared timer. It goes high at expiry and stays high until the timer reloads.
- `strt`, out, 1: one-cycle start pulse to the shared timer.
- `btn_db`, out, N: debounced levels (registered).
- `press`, out, N: one-cycle pulse when `btn_db[i]` changes from 0 to 1.
- `release`, out, N: one-cycle pulse when `btn_db[i]` changes from 1 to 0.
- `busy`, out, 1: high in every state except `IDLE`.
- `sel`, out, SELW: index of the channel being served. Holds its last value while idle.

## Operation
- **Input synchronizer:** each `btn[i]` passes through two flops to give `bs[i]`. All comparisons use `bs`.
- **Mismatch vector:** `mm = bs ^ btn_db`.
- **Round-robin pointer `ptr`:** searches start at `ptr` and wrap from N-1 to 0. The first `i` with `mm[i]=1` wins.
- **FSM states:** `IDLE`, `START`, `WAIT`, `SAMPLE`, `RECOVER`.
  - `IDLE`: if `times_up==0` and `mm!=0`, set `sel` to the winning channel and go to `START`. If `times_up==1`, stay in `IDLE`; the timer is not yet reloaded.
  - `START`: `strt=1` for exactly this cycle, then go to `WAIT`.
  - `WAIT`: stay until `times_up==1`, then go to `SAMPLE`.
  - `SAMPLE`:
    - If `bs[sel]!=btn_db[sel]`: set `btn_db[sel]<=bs[sel]` and pulse `press[sel]` (new level 1) or `release[sel]` (new level 0) on the next cycle.
    - If they are equal: the change was a glitch. Make no change and no pulse.
    - Set `ptr<=(sel==N-1)?0:sel+1`, then go to `RECOVER`.
  - `RECOVER`: stay until `times_up==0`, then go to `IDLE`.
- Channels that change while another channel is being served are not latched. Because the mismatch is level-based, they are picked up at the next `IDLE` evaluation. No event is lost unless it reverts before it is served.
- At most one channel updates per timer period. `press` and `release` are never both high for the same channel. At most one bit of `press|release` is set in any cycle.
- **Reset, including mid-operation:**
  - State returns to `IDLE`.
  - `strt`, `btn_db`, `press`, `release`, `busy`, `sel`, `ptr` all go to 0, and the synchronizer flops clear.
  - A timer left running is tolerated by the `times_up==0` guard in `IDLE`.

## Timing
- `bs` lags `btn` by 2 cycles.
- `IDLE` to `strt` high: 1 cycle after `IDLE` sees `mm!=0` (`strt` is registered and asserted in `START`).
- `times_up` rise to `btn_db` update: the `SAMPLE` state is entered on the cycle after `times_up` is first sampled high. `btn_db`, `press` and `release` are visible one cycle after that.
- The `press`/`release` pulse is exactly 1 cycle wide and coincides with the first cycle of the new `btn_db` value.
- The earliest next `strt` is 2 cycles after `times_up` falls (`RECOVER`, then `IDLE`, then `START`).
- `busy` is registered, decoded from the state, and goes high in the cycle `START` is entered.

## Test plan
- Reset behaviour: apply `rst` for 3 cycles with `btn=4'hF` -> all outputs 0 during reset. After release, channel 0 is served first: `strt` pulse, `sel=0`.
- Single press, N=4, with a timer model that sets `times_up` 20 cycles after `strt` and holds it 5 cycles: `btn[2]` goes 0 to 1 and stays -> one `strt`, `sel=2`, `btn_db=4'b0100`, one `press[2]` pulse, no `release`.
- Glitch rejection: `btn[1]` goes high for 6 cycles, then low before `times_up` -> `btn_db` stays 0, no `press` or `release`, `ptr=2` afterwards.
- Simultaneous events with `ptr=0`: `btn` goes to `4'b1010` in one cycle -> channel 1 is served, then channel 3 is served after `times_up` falls. This gives two `strt` pulses, final `btn_db=4'b1010`, and `press[1]` then `press[3]`.
- Round-robin fairness: after serving channel 3, `btn[0]` and `btn[3]` change together -> channel 0 is served first, because `ptr` wrapped to 0.
- Reset mid-operation: assert `rst` in `WAIT` while `times_up` is held at 1 -> after reset the FSM stays in `IDLE` with no `strt` until `times_up` falls, then serves the pending mismatch.
